alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Upstream issue stage for the 8-bit ALU. Buffers operations {A, B, sel} in a
//  small FIFO behind a valid/ready port and drives them one at a time onto the
//  ALU input bus. Waits out the ALU's registered-output latency, then captures
//  the result and flags into a held output with its own valid/ready handshake.
// PARAMETERS
//  FIFO_DEPTH   4  operation queue depth; power of 2, >= 2
//  ALU_LATENCY  1  cycles from ALU inputs stable to alu_result valid; >= 1
// PORTS
//  clk          in   1   rising-edge clock
//  rst          in   1   synchronous reset, active-high
//  in_valid     in   1   operation offered
//  in_ready     out  1   queue can accept; equals !full, and is 0 while rst
//  in_a, in_b   in   8   operands
//  in_sel       in   4   ALU selection code, passed through unchanged
//  alu_a,alu_b  out  8   registered operands to the ALU
//  alu_sel      out  4   registered selection to the ALU
//  alu_result   in   8   ALU registered output
//  alu_equal,alu_greater,alu_smaller,alu_carry  in 1 each  ALU flags (comb. from operands)
//  out_valid    out  1   result held and valid
//  out_ready    in   1   consumer accepts result
//  out_result   out  8   captured ALU result
//  out_flags    out  4   {carry, equal, greater, smaller}
//  out_sel      out  4   selection code of the result's operation
//  busy         out  1   1 when state != IDLE or queue not empty
//  op_count     out  16  completed-operation count (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty, state IDLE, in-flight operation discarded.
//    out_valid is 0 in the cycle after the reset edge, including mid-operation.
//  - FIFO push on in_valid & in_ready. No bypass: when full, in_ready=0 even if
//    a pop happens in the same cycle. Pointers wrap modulo FIFO_DEPTH.
//  - FSM states: IDLE, EXEC, CAPT, HOLD.
//    IDLE: if the queue is non-empty, pop and load alu_a/alu_b/alu_sel; go to EXEC.
//    EXEC: lasts ALU_LATENCY cycles. Flags are registered at the first EXEC edge.
//      Then go to CAPT.
//    CAPT: out_result <= alu_result, out_sel <= alu_sel, out_valid <= 1; go to HOLD.
//    HOLD: outputs are held stable. On out_valid & out_ready: out_valid <= 0.
//      If the queue is non-empty, pop directly and go to EXEC; otherwise go to IDLE.
//  - alu_a, alu_b, alu_sel hold their value from the pop until the next pop.
//  - Latency, for a push at edge N into an empty, idle block: out_valid rises at
//    edge N+2+ALU_LATENCY.
//  - Back-to-back issue period is 2+ALU_LATENCY cycles, with out_ready held at 1.
//  - Capacity while out_ready=0: FIFO_DEPTH queued + 1 in flight.
//  - Push and pop in the same cycle are both honoured when the queue is not full.
// CONFIGURATION
//  ALU_OP_COUNT_EN defined:
//    - op_count is a 16-bit counter, incremented on each out_valid & out_ready.
//    - Wraps 16'hFFFF -> 16'h0000. Cleared by rst.
//  ALU_OP_COUNT_EN undefined: op_count tied to 16'h0000; no counter flops.
// TESTING
//  Bench ALU stub: alu_result = A+B, registered one cycle; flags computed from A vs B.
//  1 Reset: rst=1 for 2 cycles -> out_valid=0, in_ready=0, alu_a/b/sel=0, busy=0;
//    in_ready=1 on the first cycle after release.
//  2 Single op: push A=8'h0F B=8'h01 sel=4'h0 at edge N ->
//    out_valid rises at N+3, out_result=8'h10, out_flags=4'b0010, out_sel=4'h0.
//  3 Fill: out_ready=0, offer 6 ops -> 5 accepted, in_ready=0.
//    One out handshake -> 6th op accepted on the next edge.
//  4 Backpressure: out_ready=0 for 10 cycles in HOLD ->
//    out_result, out_flags, alu_a, alu_b, alu_sel are unchanged every cycle.
//  5 Streaming: 4 ops queued, out_ready=1 -> 4 results in push order, out_valid
//    pulses every 3 cycles; busy falls after the last handshake.
//  6 Reset mid-EXEC with 2 queued -> next cycle out_valid=0, queue empty.
//    With ALU_OP_COUNT_EN and op_count preloaded to 16'hFFFF (force),
//    one handshake -> op_count=16'h0000.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Issue stage for the 8-bit ALU: operation FIFO, fixed-latency execute, held result.
// Optional completed-operation counter enabled by defining ALU_OP_COUNT_EN.
module alu_op_sequencer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int ALU_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    input  logic [3:0]  in_sel,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_sel,
    input  logic [7:0]  alu_result,
    input  logic        alu_equal,
    input  logic        alu_greater,
    input  logic        alu_smaller,
    input  logic        alu_carry,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_result,
    output logic [3:0]  out_flags,
    output logic [3:0]  out_sel,
    output logic        busy,
    output logic [15:0] op_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] CAPT = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] sel;
    } op_t;

    op_t           mem [FIFO_DEPTH];
    op_t           head;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          hs;
    logic [1:0]    state;
    logic [CW-1:0] exec_cnt;
    logic          exec_done;
    logic [3:0]    flag_q;

    // Extra pointer MSB distinguishes full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                   (wr_ptr[AW] != rd_ptr[AW]);

    assign in_ready  = !full && !rst;
    assign push      = in_valid && in_ready;
    assign hs        = out_valid && out_ready;
    assign head      = mem[rd_ptr[AW-1:0]];
    assign exec_done = (exec_cnt == CW'(ALU_LATENCY - 1));
    assign busy      = (state != IDLE) || !empty;

    always_comb begin
        pop = 1'b0;
        if (!empty) begin
            if (state == IDLE)
                pop = 1'b1;
            else if (state == HOLD && hs)
                pop = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= '{a: in_a, b: in_b, sel: in_sel};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            exec_cnt   <= '0;
            flag_q     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
            out_sel    <= '0;
        end else begin
            if (pop) begin
                alu_a    <= head.a;
                alu_b    <= head.b;
                alu_sel  <= head.sel;
                exec_cnt <= '0;
            end
            unique case (state)
                IDLE: begin
                    if (pop)
                        state <= EXEC;
                end
                EXEC: begin
                    // Flags are combinational from the operands, stable all of EXEC.
                    if (exec_cnt == '0)
                        flag_q <= {alu_carry, alu_equal,
                                   alu_greater, alu_smaller};
                    if (exec_done)
                        state <= CAPT;
                    else
                        exec_cnt <= exec_cnt + 1'b1;
                end
                CAPT: begin
                    out_result <= alu_result;
                    out_sel    <= alu_sel;
                    out_flags  <= flag_q;
                    out_valid  <= 1'b1;
                    state      <= HOLD;
                end
                HOLD: begin
                    if (hs) begin
                        out_valid <= 1'b0;
                        state     <= pop ? EXEC : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_OP_COUNT_EN
    logic [15:0] op_count_q;

    always_ff @(posedge clk) begin
        if (rst)
            op_count_q <= '0;
        else if (hs)
            op_count_q <= op_count_q + 16'd1;
    end

    assign op_count = op_count_q;
`else
    assign op_count = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized self-checking bench for alu_op_sequencer with an adder ALU stub.
// Reference model: queue of accepted operations, results expected in push order.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic [3:0]  in_sel = '0;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_sel;
    logic [7:0]  alu_result = '0;
    logic        alu_equal;
    logic        alu_greater;
    logic        alu_smaller;
    logic        alu_carry;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_result;
    logic [3:0]  out_flags;
    logic [3:0]  out_sel;
    logic        busy;
    logic [15:0] op_count;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] sel;
    } op_t;

    op_t         exp_q[$];
    int          hs_cyc[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cycle = 0;
    int          cnt_model = 0;
    bit          last_push;
    bit          last_hs;

    alu_op_sequencer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result),
        .alu_equal(alu_equal), .alu_greater(alu_greater),
        .alu_smaller(alu_smaller), .alu_carry(alu_carry),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags),
        .out_sel(out_sel), .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk)
        alu_result <= alu_a + alu_b;

    assign alu_equal   = (alu_a == alu_b);
    assign alu_greater = (alu_a > alu_b);
    assign alu_smaller = (alu_a < alu_b);
    assign alu_carry   = ({1'b0, alu_a} + {1'b0, alu_b}) > 9'd255;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cycle);
        end
    endtask

    function automatic logic [3:0] exp_flags(input op_t o);
        int s;
        s = int'(o.a) + int'(o.b);
        return {s > 255, o.a == o.b, o.a > o.b, o.a < o.b};
    endfunction

    // Called just after a negedge, once inputs are driven; returns at next negedge.
    task automatic tick(input bit chk_rdy = 1'b0);
        op_t o;
        logic [7:0] s;
        #1;
        last_push = !rst && in_valid && in_ready;
        last_hs   = !rst && out_valid && out_ready;
        if (chk_rdy && !rst) begin
            if (exp_q.size() >= 5)
                chk("rdy_full", in_ready, 0);
            else if (exp_q.size() <= 3)
                chk("rdy_room", in_ready, 1);
        end
        if (last_hs) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 1, 0);
            end else begin
                o = exp_q.pop_front();
                s = o.a + o.b;
                chk("result", out_result, s);
                chk("flags", out_flags, exp_flags(o));
                chk("sel", out_sel, o.sel);
            end
            hs_cyc.push_back(cycle);
            cnt_model = (cnt_model + 1) % 65536;
        end
        if (last_push)
            exp_q.push_back('{a: in_a, b: in_b, sel: in_sel});
        @(posedge clk);
        cycle++;
        if (rst) begin
            exp_q.delete();
            cnt_model = 0;
        end
        @(negedge clk);
    endtask

    task automatic set_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] sel);
        in_a   = a;
        in_b   = b;
        in_sel = sel;
    endtask

    initial begin
        int k;
        int idx;
        logic [7:0] h_res, h_a, h_b;
        logic [3:0] h_flg, h_sel;

        @(negedge clk);
        // Reset
        rst = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_sel", alu_sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_op_count", op_count, 0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", in_ready, 1);

        // Single op latency
        set_op(8'h0F, 8'h01, 4'h0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 10) begin
            tick();
            k++;
        end
        chk("latency", k, 3);
        chk("single_res", out_result, 8'h10);
        chk("single_flags", out_flags, 4'b0010);
        chk("single_sel", out_sel, 4'h0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        chk("single_idle_busy", busy, 0);

        // Fill with out_ready low: 4 queued + 1 in flight
        idx = 0;
        in_valid = 1'b1;
        repeat (12) begin
            set_op(8'(idx * 17 + 3), 8'(200 - idx * 9), 4'(idx + 1));
            tick();
            if (last_push)
                idx++;
            if (idx == 6)
                break;
        end
        chk("fill_count", idx, 5);
        chk("fill_in_ready", in_ready, 0);
        chk("fill_out_valid", out_valid, 1);

        // Backpressure hold
        h_res = out_result;
        h_flg = out_flags;
        h_a   = alu_a;
        h_b   = alu_b;
        h_sel = alu_sel;
        repeat (10) begin
            tick();
            chk("hold_res", out_result, h_res);
            chk("hold_flags", out_flags, h_flg);
            chk("hold_alu_a", alu_a, h_a);
            chk("hold_alu_b", alu_b, h_b);
            chk("hold_alu_sel", alu_sel, h_sel);
        end
        chk("hold_first_a", h_a, 8'd3);

        // One handshake frees a slot for the 6th op
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        chk("refill_in_ready", in_ready, 1);
        tick();
        chk("sixth_pushed", last_push, 1);
        in_valid = 1'b0;

        // Streaming drain
        hs_cyc.delete();
        out_ready = 1'b1;
        k = 0;
        while (exp_q.size() > 0 && k < 60) begin
            tick();
            k++;
        end
        chk("stream_drained", exp_q.size(), 0);
        chk("stream_count", hs_cyc.size(), 5);
        for (int i = 1; i < hs_cyc.size(); i++)
            chk("stream_period", hs_cyc[i] - hs_cyc[i-1], 3);
        chk("stream_busy", busy, 0);
        chk("stream_out_valid", out_valid, 0);

        // Randomized traffic
        repeat (400) begin
            in_valid  = ($urandom_range(0, 9) < 6);
            out_ready = ($urandom_range(0, 9) < 5);
            set_op(8'($urandom), 8'($urandom), 4'($urandom));
            if ($urandom_range(0, 7) == 0)
                in_b = in_a;
            tick(1'b1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        k = 0;
        while ((exp_q.size() > 0 || busy) && k < 100) begin
            tick(1'b1);
            k++;
        end
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_busy", busy, 0);
`ifdef ALU_OP_COUNT_EN
        chk("rand_op_count", op_count, cnt_model);
`else
        chk("rand_op_count", op_count, 0);
`endif

        // Reset mid-EXEC with two queued
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_op(8'h11, 8'h22, 4'h3);
        tick();
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 10) begin
            tick();
            k++;
        end
        in_valid = 1'b1;
        repeat (3) begin
            set_op(8'($urandom), 8'($urandom), 4'($urandom));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pre_rst_queued", exp_q.size(), 3);
        chk("pre_rst_valid", out_valid, 0);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_alu_a", alu_a, 0);
        chk("mid_rst_op_count", op_count, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_busy", busy, 0);
        out_ready = 1'b0;

`ifdef ALU_OP_COUNT_EN
        // Counter wrap
        in_valid = 1'b1;
        set_op(8'h01, 8'h02, 4'h5);
        tick();
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 10) begin
            tick();
            k++;
        end
        force dut.op_count_q = 16'hFFFF;
        #1;
        release dut.op_count_q;
        chk("preload", op_count, 16'hFFFF);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("wrap", op_count, 16'h0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
